alu_ctrl_fsm: RTL and testbench

Multicycle control state machine that sequences each 8-bit instruction through fetch, decode, execute, memory and writeback. It is the driver end of the datapath's ALU-operand interface: every cycle it produces the 3-bit operand-B select (codes 0–5), the operand-A select and the ALU operation. It also produces every PC, IR, memory, register-file and flag strobe. It sits beside the datapath, takes the instruction register and the N/Z flags, and runs one instruction at a time.

---
 rtl/alu_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multicycle control sequencer for an 8-bit accumulator-style datapath.
// Each instruction is walked through FETCH, DECODE, EXEC/MEM and WB. Every strobe and
// mux select is decoded from the current state, plus instr in DECODE/EXEC and the
// flags in BRANCH.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset, forces RESET
//   instr[7:0]  in   current IR; opcode = instr[3:0], ORI = instr[2:0]==3'b111
//   n_flag      in   registered negative flag
//   z_flag      in   registered zero flag
//   alu2_sel    out  operand-B select (0..5)
//   alu1_sel    out  operand-A select (0 = PC, 1 = R1)
//   alu_op      out  ALU operation
//   pc_write, ir_load, mem_read, mem_write, addr_sel, mdr_load,
//   reg_write, reg_in_sel, flag_write   out  datapath strobes/selects
//   halted      out  high in HALT
//   state[3:0]  out  current state encoding (debug)
module alu_ctrl_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       n_flag,
    input  logic       z_flag,
    output logic [2:0] alu2_sel,
    output logic       alu1_sel,
    output logic [2:0] alu_op,
    output logic       pc_write,
    output logic       ir_load,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       mdr_load,
    output logic       reg_write,
    output logic       reg_in_sel,
    output logic       flag_write,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_LD_MEM = 4'd5,
        S_LD_WB  = 4'd6,
        S_ST_MEM = 4'd7,
        S_BRANCH = 4'd8,
        S_JR     = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [3:0] OPC_LOAD  = 4'b0000;
    localparam logic [3:0] OPC_STOP  = 4'b0001;
    localparam logic [3:0] OPC_STORE = 4'b0010;
    localparam logic [3:0] OPC_SHIFT = 4'b0011;
    localparam logic [3:0] OPC_ADD   = 4'b0100;
    localparam logic [3:0] OPC_BPZ   = 4'b0101;
    localparam logic [3:0] OPC_SUB   = 4'b0110;
    localparam logic [3:0] OPC_NAND  = 4'b1000;
    localparam logic [3:0] OPC_BNZ   = 4'b1001;
    localparam logic [3:0] OPC_JR    = 4'b1100;
    localparam logic [3:0] OPC_BZ    = 4'b1101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_NAND  = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SHIFT = 3'b101;

    localparam logic [2:0] B_R2    = 3'd0;
    localparam logic [2:0] B_ONE   = 3'd1;
    localparam logic [2:0] B_SEXT4 = 3'd2;
    localparam logic [2:0] B_ZEXT3 = 3'd3;
    localparam logic [2:0] B_ZEXT5 = 3'd4;
    localparam logic [2:0] B_ZERO  = 3'd5;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode;
    logic       is_ori;
    logic       unused_instr_hi;

    assign opcode = instr[3:0];
    // ORI reuses instr[3] as an immediate bit, so it is matched on the low three bits only
    assign is_ori = (instr[2:0] == 3'b111);
    // immediate fields are consumed by the datapath, not by the sequencer
    assign unused_instr_hi = ^instr[7:4];

    assign state = state_q;

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                if (is_ori) begin
                    state_d = S_EXEC;
                end else begin
                    case (opcode)
                        OPC_ADD, OPC_SUB, OPC_NAND, OPC_SHIFT: state_d = S_EXEC;
                        OPC_LOAD:                              state_d = S_LD_MEM;
                        OPC_STORE:                             state_d = S_ST_MEM;
                        OPC_BZ, OPC_BNZ, OPC_BPZ:              state_d = S_BRANCH;
                        OPC_JR:                                state_d = S_JR;
                        OPC_STOP:                              state_d = S_HALT;
                        default:                               state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_LD_MEM: state_d = S_LD_WB;
            S_LD_WB:  state_d = S_FETCH;
            S_ST_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JR:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase
    end

    // output decode
    always_comb begin
        alu2_sel   = B_R2;
        alu1_sel   = 1'b0;
        alu_op     = ALU_ADD;
        pc_write   = 1'b0;
        ir_load    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;
        mdr_load   = 1'b0;
        reg_write  = 1'b0;
        reg_in_sel = 1'b0;
        flag_write = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_load  = 1'b1;
                alu2_sel = B_ONE;
                pc_write = 1'b1;
            end
            // branch target PC + sext(imm4) is computed speculatively into ALUOut
            S_DECODE: begin
                alu2_sel = B_SEXT4;
            end
            S_EXEC: begin
                alu1_sel   = 1'b1;
                flag_write = 1'b1;
                if (is_ori) begin
                    alu2_sel = B_ZEXT5;
                    alu_op   = ALU_OR;
                end else begin
                    case (opcode)
                        OPC_SUB:   alu_op = ALU_SUB;
                        OPC_NAND:  alu_op = ALU_NAND;
                        OPC_SHIFT: begin
                            alu2_sel = B_ZEXT3;
                            alu_op   = ALU_SHIFT;
                        end
                        default:   alu_op = ALU_ADD;
                    endcase
                end
            end
            S_WB: begin
                reg_write = 1'b1;
            end
            S_LD_MEM: begin
                mem_read = 1'b1;
                addr_sel = 1'b1;
                mdr_load = 1'b1;
            end
            S_LD_WB: begin
                reg_write  = 1'b1;
                reg_in_sel = 1'b1;
            end
            S_ST_MEM: begin
                mem_write = 1'b1;
                addr_sel  = 1'b1;
            end
            // flags are the ones latched by the previous EXEC
            S_BRANCH: begin
                case (opcode)
                    OPC_BZ:  pc_write = z_flag;
                    OPC_BNZ: pc_write = ~z_flag;
                    OPC_BPZ: pc_write = ~n_flag;
                    default: pc_write = 1'b0;
                endcase
            end
            S_JR: begin
                alu1_sel = 1'b1;
                alu2_sel = B_ZERO;
                pc_write = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: table-driven, scoreboarded check of alu_ctrl_fsm.
// Expected per-cycle output vectors are pushed when an instruction is driven and
// popped/compared on the falling edge while the DUT walks through its states.
module tb_alu_ctrl_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       n_flag;
    logic       z_flag;
    logic [2:0] alu2_sel;
    logic       alu1_sel;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       ir_load;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic       mdr_load;
    logic       reg_write;
    logic       reg_in_sel;
    logic       flag_write;
    logic       halted;
    logic [3:0] state;

    always #5 clock = ~clock;

    alu_ctrl_fsm dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .n_flag     (n_flag),
        .z_flag     (z_flag),
        .alu2_sel   (alu2_sel),
        .alu1_sel   (alu1_sel),
        .alu_op     (alu_op),
        .pc_write   (pc_write),
        .ir_load    (ir_load),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr_sel   (addr_sel),
        .mdr_load   (mdr_load),
        .reg_write  (reg_write),
        .reg_in_sel (reg_in_sel),
        .flag_write (flag_write),
        .halted     (halted),
        .state      (state)
    );

    // sb = {pc_write, ir_load, mem_read, mem_write, addr_sel, mdr_load,
    //       reg_write, reg_in_sel, flag_write, halted}
    typedef struct packed {
        logic [3:0] st;
        logic [2:0] a2;
        logic       a1;
        logic [2:0] op;
        logic [9:0] sb;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } sb_t;

    typedef struct {
        string      name;
        logic [7:0] instr;
        logic       n;
        logic       z;
        int         ncyc;
        exp_t [3:0] seq;
    } vec_t;

    localparam exp_t RST   = {4'd0,  3'd0, 1'b0, 3'b000, 10'b0000000000};
    localparam exp_t FET   = {4'd1,  3'd1, 1'b0, 3'b000, 10'b1110000000};
    localparam exp_t DEC   = {4'd2,  3'd2, 1'b0, 3'b000, 10'b0000000000};
    localparam exp_t EADD  = {4'd3,  3'd0, 1'b1, 3'b000, 10'b0000000010};
    localparam exp_t ESUB  = {4'd3,  3'd0, 1'b1, 3'b001, 10'b0000000010};
    localparam exp_t ENAND = {4'd3,  3'd0, 1'b1, 3'b011, 10'b0000000010};
    localparam exp_t ESHF  = {4'd3,  3'd3, 1'b1, 3'b101, 10'b0000000010};
    localparam exp_t EORI  = {4'd3,  3'd4, 1'b1, 3'b100, 10'b0000000010};
    localparam exp_t WBK   = {4'd4,  3'd0, 1'b0, 3'b000, 10'b0000001000};
    localparam exp_t LDM   = {4'd5,  3'd0, 1'b0, 3'b000, 10'b0010110000};
    localparam exp_t LDW   = {4'd6,  3'd0, 1'b0, 3'b000, 10'b0000001100};
    localparam exp_t STM   = {4'd7,  3'd0, 1'b0, 3'b000, 10'b0001100000};
    localparam exp_t BRT   = {4'd8,  3'd0, 1'b0, 3'b000, 10'b1000000000};
    localparam exp_t BRN   = {4'd8,  3'd0, 1'b0, 3'b000, 10'b0000000000};
    localparam exp_t JRS   = {4'd9,  3'd5, 1'b1, 3'b000, 10'b1000000000};
    localparam exp_t HLT   = {4'd10, 3'd0, 1'b0, 3'b000, 10'b0000000001};

    sb_t  sbq[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    exp_t got;

    assign got = {state, alu2_sel, alu1_sel, alu_op,
                  pc_write, ir_load, mem_read, mem_write, addr_sel, mdr_load,
                  reg_write, reg_in_sel, flag_write, halted};

    // scoreboard compare on the falling edge, away from state updates
    always @(negedge clock) begin
        sb_t s;
        if (sbq.size() > 0) begin
            s = sbq.pop_front();
            checks++;
            if (got !== s.e) begin
                errors++;
                $display("FAIL %s: got state=%0d vec=%h, required state=%0d vec=%h",
                         s.name, got.st, got, s.e.st, s.e);
            end
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL %s mem_excl: got mem_read=1 mem_write=1, required not both",
                         s.name);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_cyc(input string nm, input exp_t e);
        sb_t s;
        s.name = nm;
        s.e    = e;
        sbq.push_back(s);
    endtask

    task automatic add_vec(input string nm, input logic [7:0] i, input logic n,
                           input logic z, input int nc,
                           input exp_t e0, input exp_t e1, input exp_t e2, input exp_t e3);
        vec_t v;
        v.name   = nm;
        v.instr  = i;
        v.n      = n;
        v.z      = z;
        v.ncyc   = nc;
        v.seq[0] = e0;
        v.seq[1] = e1;
        v.seq[2] = e2;
        v.seq[3] = e3;
        vecs.push_back(v);
    endtask

    // called at the start of a FETCH cycle; returns at the start of the next one
    task automatic run_vec(input vec_t v);
        instr  = v.instr;
        n_flag = v.n;
        z_flag = v.z;
        for (int c = 0; c < v.ncyc; c++) begin
            expect_cyc($sformatf("%s c%0d", v.name, c), v.seq[c]);
        end
        for (int c = 0; c < v.ncyc; c++) begin
            tick();
        end
    endtask

    initial begin
        reset  = 1'b1;
        instr  = 8'h00;
        n_flag = 1'b0;
        z_flag = 1'b0;

        add_vec("add",        8'h04, 1'b0, 1'b0, 4, FET, DEC, EADD,  WBK);
        add_vec("sub",        8'h06, 1'b0, 1'b0, 4, FET, DEC, ESUB,  WBK);
        add_vec("nand",       8'h08, 1'b0, 1'b0, 4, FET, DEC, ENAND, WBK);
        add_vec("shift",      8'h23, 1'b0, 1'b0, 4, FET, DEC, ESHF,  WBK);
        add_vec("ori_f7",     8'hF7, 1'b0, 1'b0, 4, FET, DEC, EORI,  WBK);
        add_vec("ori_0f",     8'h0F, 1'b0, 1'b0, 4, FET, DEC, EORI,  WBK);
        add_vec("load",       8'h00, 1'b0, 1'b0, 4, FET, DEC, LDM,   LDW);
        add_vec("store",      8'h02, 1'b0, 1'b0, 3, FET, DEC, STM,   RST);
        add_vec("bz_taken",   8'h3D, 1'b0, 1'b1, 3, FET, DEC, BRT,   RST);
        add_vec("bz_not",     8'h3D, 1'b0, 1'b0, 3, FET, DEC, BRN,   RST);
        add_vec("bnz_taken",  8'h39, 1'b1, 1'b0, 3, FET, DEC, BRT,   RST);
        add_vec("bnz_not",    8'h39, 1'b0, 1'b1, 3, FET, DEC, BRN,   RST);
        add_vec("bpz_taken",  8'h35, 1'b0, 1'b1, 3, FET, DEC, BRT,   RST);
        add_vec("bpz_not",    8'h35, 1'b1, 1'b0, 3, FET, DEC, BRN,   RST);
        add_vec("jr",         8'h4C, 1'b0, 1'b0, 3, FET, DEC, JRS,   RST);
        add_vec("nop",        8'h0A, 1'b0, 1'b0, 2, FET, DEC, RST,   RST);
        add_vec("undef_0b",   8'h0B, 1'b0, 1'b0, 2, FET, DEC, RST,   RST);
        add_vec("undef_0e",   8'hEE, 1'b0, 1'b0, 2, FET, DEC, RST,   RST);

        // reset held for two edges, then released: next edge gives FETCH
        tick();
        expect_cyc("reset_hold", RST);
        tick();
        reset = 1'b0;
        expect_cyc("reset_release", RST);
        tick();

        foreach (vecs[k]) begin
            run_vec(vecs[k]);
        end

        // reset in LD_MEM aborts the load before its writeback
        instr  = 8'h00;
        expect_cyc("ld_abort fetch", FET);
        expect_cyc("ld_abort decode", DEC);
        tick();
        tick();
        expect_cyc("ld_abort ld_mem", LDM);
        reset = 1'b1;
        tick();
        expect_cyc("ld_abort reset", RST);
        reset = 1'b0;
        tick();
        run_vec(vecs[0]);

        // stop: halted for 20 cycles with no strobes, only reset leaves
        instr = 8'h01;
        expect_cyc("stop fetch", FET);
        expect_cyc("stop decode", DEC);
        for (int c = 0; c < 20; c++) begin
            expect_cyc($sformatf("halt c%0d", c), HLT);
        end
        for (int c = 0; c < 22; c++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        expect_cyc("halt_reset", RST);
        reset = 1'b0;
        tick();
        run_vec(vecs[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
